uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning the number of tick pulses per bit period.
REQ-002 SHALL have parameter SYS_CLK_HZ, default 100_000_000, documentation only (tick generation is external).
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  8  last correctly framed byte.
REQ-008 SHALL have port rx_done  output  1  one-clk pulse when rx_data updates.
REQ-009 SHALL have port rx_busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port frame_err  output  1  one-clk pulse on a bad stop bit.

Function
REQ-011 SHALL synchronise rx through two flops (rx_s) before any use; input-to-rx_s latency is 2 clk.
REQ-012 SHALL implement states IDLE, START, DATA, STOP (plus PARITY when UART_RX_PARITY_EN is defined).
REQ-013 IDLE SHALL move to START on a falling edge of rx_s (previous 1, current 0), with the tick counter cleared.
REQ-014 START SHALL count ticks; at tick count OVERSAMPLE/2-1 (7), rx_s=0 goes to DATA with the counter cleared; rx_s=1 is a glitch and returns to IDLE with no outputs asserted.
REQ-015 DATA SHALL sample rx_s at tick count OVERSAMPLE-1 into the shift register, LSB first; after 8 bits it goes to STOP (or PARITY).
REQ-016 STOP SHALL sample at tick count OVERSAMPLE-1; rx_s=1 loads rx_data from the shift register and pulses rx_done; rx_s=0 pulses frame_err and leaves rx_data unchanged; either way it goes to IDLE.
REQ-017 rx_done and frame_err SHALL be registered, assert in the clk after the sampling tick, last exactly one clk, and never assert together.
REQ-018 with no tick pulses, state and counters SHALL hold.
REQ-019 a held-low line (break) SHALL produce one frame_err; no new frame starts until rx_s has been high for at least one clk.
REQ-020 the tick counter SHALL be $clog2(OVERSAMPLE) bits wide, wrap to 0 after OVERSAMPLE-1, and the bit counter SHALL be 3 bits.
REQ-021 a falling edge arriving in the same clk as the STOP-to-IDLE transition SHALL be detected (back-to-back frames with 1 stop bit).

Reset
REQ-022 rst SHALL force IDLE, clear counters and the shift register, and set rx_data=0x00, rx_done=0, frame_err=0, rx_busy=0, and both synchroniser flops to 1.
REQ-023 rst mid-frame SHALL abort the frame with no rx_done or frame_err, and reception SHALL resume on the next falling edge after release.

Configuration
REQ-024 macro UART_RX_PARITY_EN defined: a PARITY state between DATA and STOP samples an even-parity bit, and an output parity_err (1 bit) pulses together with rx_done on a mismatch; the byte is still delivered.
REQ-025 macro UART_RX_PARITY_EN undefined: no PARITY state, no parity_err port, frame = start + 8 data + stop.

Structure
REQ-026 a shared package SHALL hold the state enum, OVERSAMPLE default, and DATA_BITS=8 constant.
REQ-027 the two-flop synchroniser SHALL be sub-module uart_rx_sync (clk, rst, async_in, sync_out, reset value 1).
REQ-028 the oversample tick SHALL come from a baud_tick_gen instance configured for 9600x16 (count 651 at 100 MHz), outside this block.

Verification (100 MHz clk, tick every 651 clk, bit = 16 ticks)
REQ-029 send 0x30 with a valid stop bit -> rx_data=0x30 and one rx_done pulse about 9.5 bit times after the start edge; frame_err=0.
REQ-030 send a 3-tick low glitch -> return to IDLE, rx_busy drops, no rx_done or frame_err, rx_data unchanged.
REQ-031 send 0xA5 with stop bit 0 after a prior 0x30 -> one frame_err pulse and rx_data stays 0x30.
REQ-032 send 0x55 then 0xAA back-to-back with 1 stop bit -> two rx_done pulses with rx_data 0x55 then 0xAA.
REQ-033 assert rst for 1 clk during bit 4 of 0xFF, then send 0x12 -> no pulse for the aborted frame, and rx_data=0x12 with rx_done.
REQ-034 with UART_RX_PARITY_EN defined, send 0x31 with parity bit 0 (wrong) -> rx_done, parity_err and rx_data=0x31 in the same clk.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receiver
//
// Contents: receiver state enum, default oversample factor, data bits per frame.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_rx_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int DATA_BITS          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the asynchronous rx line
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset, both flops reset to 1 (line idle)
//   async_in in   asynchronous input
//   sync_out out  input synchronised to clk, 2 clk latency
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 8 data bits, 1 stop bit
//
// Parameters:
//   OVERSAMPLE  tick pulses per bit period
//   SYS_CLK_HZ  system clock frequency, informational (tick comes from outside)
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   tick       in   one-clk pulse at OVERSAMPLE x baud
//   rx         in   asynchronous serial line, idle high
//   rx_data    out  last correctly framed byte
//   rx_done    out  one-clk pulse when rx_data updates
//   rx_busy    out  high whenever a frame is in progress
//   frame_err  out  one-clk pulse on a bad stop bit
//   parity_err out  (UART_RX_PARITY_EN only) pulses with rx_done on an even-parity mismatch
// Optional feature macro: UART_RX_PARITY_EN.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int SYS_CLK_HZ = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] TICK_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    // The half-bit start check and the counter width need at least a few ticks per bit.
    if (OVERSAMPLE < 4 || SYS_CLK_HZ < OVERSAMPLE) begin : g_cfg_check
        $error("uart_rx: OVERSAMPLE must be >= 4 and below SYS_CLK_HZ");
    end

    uart_rx_state_e       state_q;
    logic [CW-1:0]        tick_cnt_q;
    logic [CW-1:0]        tick_cnt_d;
    logic [2:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 rx_s;
    logic                 rx_prev_q;
    logic                 fall;
    logic                 at_last;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q;
`endif

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx),
        .sync_out (rx_s)
    );

    // rx_prev_q tracks rx_s every clk regardless of state, so a line that
    // stayed low (break) cannot look like a new start edge until it has risen.
    assign fall       = rx_prev_q & ~rx_s;
    assign at_last    = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = at_last ? '0 : tick_cnt_q + 1'b1;
    assign shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
    assign rx_busy    = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_prev_q  <= 1'b1;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_prev_q <= rx_s;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q    <= ST_START;
                        tick_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (tick_cnt_q == TICK_HALF) begin
                            // Mid start bit: still low means a real frame,
                            // high means the edge was a glitch.
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            state_q    <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        tick_cnt_q <= tick_cnt_d;
                        if (at_last) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        tick_cnt_q <= tick_cnt_d;
                        if (at_last) begin
                            // Even parity: data bits plus parity bit XOR to 0.
                            par_bad_q <= rx_s ^ (^shift_q);
                            state_q   <= ST_STOP;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        tick_cnt_q <= tick_cnt_d;
                        if (at_last) begin
                            if (rx_s) begin
                                rx_data <= shift_q;
                                rx_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err <= par_bad_q;
`endif
                            end else begin
                                frame_err <= 1'b1;
                            end
                            // An edge coinciding with the return to idle starts the next frame.
                            if (fall) begin
                                state_q    <= ST_START;
                                tick_cnt_q <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
